uart_top_8n1: RTL and testbench



---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_baud_gen.sv | 26 ++
 rtl/uart_top_8n1.sv | 165 ++++++++++++++++
 tb/tb_uart_top_8n1.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM state encodings for the 8N1 UART.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Fractional baud generator producing a one-cycle tick at 16x the bit rate.
module uart_baud_gen (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] baud_freq,
  input  logic [15:0] baud_limit,
  output logic        baud_clk
);

  logic [15:0] counter;

  // Tick is registered so it stays low on the cycle after reset even when baud_limit is 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      counter  <= '0;
      baud_clk <= 1'b0;
    end else if (counter >= baud_limit) begin
      counter  <= counter - baud_limit;
      baud_clk <= 1'b1;
    end else begin
      counter  <= counter + {4'd0, baud_freq};
      baud_clk <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_top_8n1.sv
// 8N1 UART with independent transmitter and receiver sharing one baud tick.
// Define UART_RX_STOP_CHECK_EN to discard received bytes whose stop bit reads 0.
module uart_top_8n1
  import uart_pkg::*;
#(
  parameter int RX_SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ser_in,
  output logic        ser_out,
  input  logic [7:0]  tx_data,
  input  logic        new_tx_data,
  output logic        tx_busy,
  output logic [7:0]  rx_data,
  output logic        new_rx_data,
  input  logic [11:0] baud_freq,
  input  logic [15:0] baud_limit,
  output logic        baud_clk
);

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  txState_t txState;
  logic [7:0] txShift;
  logic [3:0] txTick;
  logic [2:0] txBitCnt;
  logic       txWait;

  rxState_t rxState;
  logic [RX_SYNC_STAGES-1:0] rxSync;
  logic       rxIn;
  logic [7:0] rxShift;
  logic [3:0] rxTick;
  logic [2:0] rxBitCnt;

  uart_baud_gen baudGen (
    .clock      (clock),
    .reset      (reset),
    .baud_freq  (baud_freq),
    .baud_limit (baud_limit),
    .baud_clk   (baud_clk)
  );

  // txWait holds the line idle until the first tick after acceptance starts the frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      txState  <= TX_IDLE;
      txShift  <= '0;
      txTick   <= '0;
      txBitCnt <= '0;
      txWait   <= 1'b0;
      ser_out  <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      case (txState)
        TX_IDLE: begin
          ser_out <= 1'b1;
          if (new_tx_data && !tx_busy) begin
            txShift <= tx_data;
            tx_busy <= 1'b1;
            txWait  <= 1'b1;
            txTick  <= '0;
            txState <= TX_START;
          end
        end
        TX_START: if (baud_clk) begin
          if (txWait) begin
            txWait  <= 1'b0;
            ser_out <= 1'b0;
            txTick  <= '0;
          end else begin
            txTick <= txTick + 4'd1;
            if (txTick == LAST_TICK) begin
              ser_out  <= txShift[0];
              txShift  <= {1'b0, txShift[7:1]};
              txBitCnt <= '0;
              txState  <= TX_DATA;
            end
          end
        end
        TX_DATA: if (baud_clk) begin
          txTick <= txTick + 4'd1;
          if (txTick == LAST_TICK) begin
            if (txBitCnt == LAST_BIT) begin
              ser_out <= 1'b1;
              txState <= TX_STOP;
            end else begin
              ser_out  <= txShift[0];
              txShift  <= {1'b0, txShift[7:1]};
              txBitCnt <= txBitCnt + 3'd1;
            end
          end
        end
        TX_STOP: if (baud_clk) begin
          txTick <= txTick + 4'd1;
          if (txTick == LAST_TICK) begin
            tx_busy <= 1'b0;
            txState <= TX_IDLE;
          end
        end
        default: txState <= TX_IDLE;
      endcase
    end
  end

  assign rxIn = rxSync[RX_SYNC_STAGES-1];

  // Receiver: find mid-start, then sample every OVERSAMPLE ticks from there.
  always_ff @(posedge clock) begin
    if (reset) begin
      rxSync      <= '1;
      rxState     <= RX_IDLE;
      rxShift     <= '0;
      rxTick      <= '0;
      rxBitCnt    <= '0;
      rx_data     <= '0;
      new_rx_data <= 1'b0;
    end else begin
      rxSync      <= {rxSync[RX_SYNC_STAGES-2:0], ser_in};
      new_rx_data <= 1'b0;
      case (rxState)
        RX_IDLE: if (!rxIn) begin
          rxTick  <= '0;
          rxState <= RX_START;
        end
        RX_START: if (baud_clk) begin
          rxTick <= rxTick + 4'd1;
          if (rxTick == MID_TICK) begin
            rxTick   <= '0;
            rxBitCnt <= '0;
            rxState  <= rxIn ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: if (baud_clk) begin
          rxTick <= rxTick + 4'd1;
          if (rxTick == LAST_TICK) begin
            rxShift  <= {rxIn, rxShift[7:1]};
            rxBitCnt <= rxBitCnt + 3'd1;
            if (rxBitCnt == LAST_BIT) rxState <= RX_STOP;
          end
        end
        RX_STOP: if (baud_clk) begin
          rxTick <= rxTick + 4'd1;
          if (rxTick == LAST_TICK) begin
            rxState <= RX_IDLE;
`ifdef UART_RX_STOP_CHECK_EN
            if (rxIn) begin
              rx_data     <= rxShift;
              new_rx_data <= 1'b1;
            end
`else
            rx_data     <= rxShift;
            new_rx_data <= 1'b1;
`endif
          end
        end
        default: rxState <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_top_8n1.sv
// Directed self-checking bench for uart_top_8n1 at baud_freq=1, baud_limit=3 (64 clocks per bit).
module tb_uart_top_8n1;

  logic        clock = 1'b0;
  logic        reset;
  logic        serInDrive;
  logic        loopback;
  logic        ser_in;
  logic        ser_out;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        new_rx_data;
  logic [11:0] baud_freq;
  logic [15:0] baud_limit;
  logic        baud_clk;

  int checkCount = 0;
  int errorCount = 0;

  logic [7:0] rxLog[$];
  logic       rxMultiPulse = 1'b0;
  logic       prevNewRx = 1'b0;

  assign ser_in = loopback ? ser_out : serInDrive;

  always #5 clock = ~clock;

  uart_top_8n1 #(.RX_SYNC_STAGES(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .ser_in      (ser_in),
    .ser_out     (ser_out),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .tx_busy     (tx_busy),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data),
    .baud_freq   (baud_freq),
    .baud_limit  (baud_limit),
    .baud_clk    (baud_clk)
  );

  // Logs every delivered byte and flags any pulse wider than one clock.
  always @(negedge clock) begin
    if (new_rx_data) rxLog.push_back(rx_data);
    if (new_rx_data && prevNewRx) rxMultiPulse = 1'b1;
    prevNewRx = new_rx_data;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    checkOutput("busyBeforeReq", 16'(tx_busy), 16'h0);
    tx_data     = data;
    new_tx_data = 1'b1;
    @(negedge clock);
    new_tx_data = 1'b0;
    checkOutput("busyAfterReq", 16'(tx_busy), 16'h1);
  endtask

  task automatic waitBusyLow(input int limit);
    int n = 0;
    while (tx_busy && n < limit) begin
      @(negedge clock);
      n++;
    end
    if (tx_busy) checkOutput("busyTimeout", 16'(tx_busy), 16'h0);
  endtask

  task automatic countTicks(input int n, output int ticks);
    ticks = 0;
    repeat (n) begin
      @(negedge clock);
      if (baud_clk) ticks++;
    end
  endtask

  // Samples each bit centre; optionally fires an ignored request during bit 4.
  task automatic txFrameCheck(input logic [7:0] data, input logic inject);
    logic [9:0] frame;
    int n = 0;
    frame = {1'b1, data, 1'b0};
    while (ser_out !== 1'b0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    checkOutput("txStartSeen", 16'(ser_out), 16'h0);
    if (ser_out !== 1'b0) return;
    waitCycles(32);
    checkOutput("txBit0", 16'(ser_out), 16'(frame[0]));
    for (int i = 1; i < 10; i++) begin
      if (inject && i == 4) begin
        waitCycles(20);
        tx_data     = 8'h3C;
        new_tx_data = 1'b1;
        @(negedge clock);
        new_tx_data = 1'b0;
        checkOutput("busyDuringInject", 16'(tx_busy), 16'h1);
        waitCycles(43);
      end else begin
        waitCycles(64);
      end
      checkOutput($sformatf("txBit%0d", i), 16'(ser_out), 16'(frame[i]));
    end
    waitCycles(31);
    checkOutput("busyEndOfStop", 16'(tx_busy), 16'h1);
    waitCycles(1);
    checkOutput("busyFall", 16'(tx_busy), 16'h0);
  endtask

  task automatic driveFrame(input logic [7:0] data, input logic stopBit, input int stopLen);
    serInDrive = 1'b0;
    waitCycles(64);
    for (int i = 0; i < 8; i++) begin
      serInDrive = data[i];
      waitCycles(64);
    end
    serInDrive = stopBit;
    waitCycles(stopLen);
    serInDrive = 1'b1;
    waitCycles(150);
  endtask

  initial begin
    int ticks;
    int base;
    int expCount;
    logic [7:0] expData;
    logic sawLow;

    reset       = 1'b1;
    serInDrive  = 1'b1;
    loopback    = 1'b0;
    tx_data     = 8'h00;
    new_tx_data = 1'b0;
    baud_freq   = 12'd1;
    baud_limit  = 16'd3;

    waitCycles(3);
    checkOutput("rstSerOut", 16'(ser_out), 16'h1);
    checkOutput("rstBusy", 16'(tx_busy), 16'h0);
    checkOutput("rstRxData", 16'(rx_data), 16'h0);
    checkOutput("rstNewRx", 16'(new_rx_data), 16'h0);
    checkOutput("rstBaudClk", 16'(baud_clk), 16'h0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("postRstBaudClk", 16'(baud_clk), 16'h0);
    checkOutput("postRstSerOut", 16'(ser_out), 16'h1);
    checkOutput("postRstBusy", 16'(tx_busy), 16'h0);

    countTicks(40, ticks);
    checkOutput("ticksF1L3", 16'(ticks), 16'd10);
    baud_limit = 16'd0;
    waitCycles(2);
    countTicks(10, ticks);
    checkOutput("ticksF1L0", 16'(ticks), 16'd10);
    baud_limit = 16'd1;
    waitCycles(5);
    countTicks(20, ticks);
    checkOutput("ticksF1L1", 16'(ticks), 16'd10);
    baud_freq  = 12'd3;
    baud_limit = 16'd5;
    waitCycles(2);
    countTicks(40, ticks);
    checkOutput("ticksF3L5", 16'(ticks), 16'd15);
    baud_freq  = 12'd1;
    baud_limit = 16'd3;
    waitCycles(10);

    applyStimulus(8'hA5);
    txFrameCheck(8'hA5, 1'b1);
    sawLow = 1'b0;
    repeat (300) begin
      @(negedge clock);
      if (ser_out == 1'b0) sawLow = 1'b1;
    end
    checkOutput("noSecondFrame", 16'(sawLow), 16'h0);
    checkOutput("busyIdleAfter", 16'(tx_busy), 16'h0);
    checkOutput("rxQuiet", 16'(rxLog.size()), 16'd0);

    loopback = 1'b1;
    base = rxLog.size();
    applyStimulus(8'h00);
    waitBusyLow(800);
    applyStimulus(8'hFF);
    waitBusyLow(800);
    applyStimulus(8'h5A);
    waitBusyLow(800);
    waitCycles(10);
    checkOutput("loopCount", 16'(rxLog.size()), 16'(base + 3));
    if (rxLog.size() == base + 3) begin
      checkOutput("loopByte0", 16'(rxLog[base]), 16'h00);
      checkOutput("loopByte1", 16'(rxLog[base+1]), 16'hFF);
      checkOutput("loopByte2", 16'(rxLog[base+2]), 16'h5A);
    end

    loopback = 1'b0;
    waitCycles(20);
    base = rxLog.size();
    driveFrame(8'h96, 1'b1, 64);
    checkOutput("rxDrivenCount", 16'(rxLog.size()), 16'(base + 1));
    checkOutput("rxDrivenData", 16'(rx_data), 16'h96);

    base = rxLog.size();
    serInDrive = 1'b0;
    waitCycles(20);
    serInDrive = 1'b1;
    waitCycles(200);
    checkOutput("glitchNoPulse", 16'(rxLog.size()), 16'(base));
    checkOutput("glitchRxHeld", 16'(rx_data), 16'h96);
    driveFrame(8'h3B, 1'b1, 64);
    checkOutput("afterGlitchCount", 16'(rxLog.size()), 16'(base + 1));
    checkOutput("afterGlitchData", 16'(rx_data), 16'h3B);

    base = rxLog.size();
    driveFrame(8'hC3, 1'b0, 48);
`ifdef UART_RX_STOP_CHECK_EN
    expCount = base;
    expData  = 8'h3B;
`else
    expCount = base + 1;
    expData  = 8'hC3;
`endif
    checkOutput("badStopCount", 16'(rxLog.size()), 16'(expCount));
    checkOutput("badStopData", 16'(rx_data), 16'(expData));
    base = rxLog.size();
    driveFrame(8'h4E, 1'b1, 64);
    checkOutput("afterBadStopData", 16'(rx_data), 16'h4E);

    loopback = 1'b1;
    base = rxLog.size();
    applyStimulus(8'h5A);
    waitCycles(300);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midRstSerOut", 16'(ser_out), 16'h1);
    checkOutput("midRstBusy", 16'(tx_busy), 16'h0);
    checkOutput("midRstNewRx", 16'(new_rx_data), 16'h0);
    checkOutput("midRstRxData", 16'(rx_data), 16'h0);
    waitCycles(2);
    reset = 1'b0;
    waitCycles(700);
    checkOutput("midRstNoByte", 16'(rxLog.size()), 16'(base));
    checkOutput("midRstIdleOut", 16'(ser_out), 16'h1);
    checkOutput("midRstIdleBusy", 16'(tx_busy), 16'h0);

    applyStimulus(8'h81);
    txFrameCheck(8'h81, 1'b0);
    waitCycles(5);
    checkOutput("post81Count", 16'(rxLog.size()), 16'(base + 1));
    checkOutput("post81Data", 16'(rx_data), 16'h81);
    checkOutput("rxPulseWidth", 16'(rxMultiPulse), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
